// File: rtl/hub75_pkg.sv
// Shared pixel type, field layout and defaults for the HUB75 receive path.
package hub75_pkg;

    typedef logic [5:0] pixel_t;

    localparam int R_LSB     = 0;
    localparam int G_LSB     = 2;
    localparam int B_LSB     = 4;
    localparam int DEF_COLS  = 32;
    localparam int DEF_ROW_W = 4;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic pixel_t pack_px(input logic [1:0] r, input logic [1:0] g,
                                       input logic [1:0] b);
        pixel_t p;
        p = '0;
        p[R_LSB +: 2] = r;
        p[G_LSB +: 2] = g;
        p[B_LSB +: 2] = b;
        return p;
    endfunction

endpackage

// File: rtl/hub75_linebuf.sv
// Two-bank ping-pong line store: one write port into the current write bank,
// one registered read port, and per-bank ownership held by the read side.
module hub75_linebuf
    import hub75_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [$clog2(COLS)-1:0] i_waddr,
    input  pixel_t                  i_wdata,
    input  logic                    i_handoff,
    input  logic                    i_free,
    input  logic                    i_free_bank,
    input  logic                    i_re,
    input  logic                    i_rbank,
    input  logic [$clog2(COLS)-1:0] i_raddr,
    output pixel_t                  o_rdata,
    output logic                    o_wsel,
    output logic [1:0]              o_busy
);

    pixel_t     r_mem [2][COLS];
    pixel_t     r_rdata;
    logic       r_wsel;
    logic [1:0] r_busy;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_wsel][i_waddr] <= i_wdata;
        end
    end

    // Handoff and free always target different banks: a handoff is only
    // issued when the write bank is not owned by the reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wsel  <= 1'b0;
            r_busy  <= '0;
            r_rdata <= '0;
        end else begin
            if (i_handoff) begin
                r_busy[r_wsel] <= 1'b1;
                r_wsel         <= ~r_wsel;
            end
            if (i_free) begin
                r_busy[i_free_bank] <= 1'b0;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_rbank][i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_wsel  = r_wsel;
    assign o_busy  = r_busy;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: oversamples the bus, rebuilds shifted lines in a
// ping-pong buffer and streams each latched line as tagged valid/ready beats.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROW_W = DEF_ROW_W,
    parameter int SYNC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mat_r,
    input  logic [1:0]              mat_g,
    input  logic [1:0]              mat_b,
    input  logic [ROW_W-1:0]        mat_row,
    input  logic                    mat_clk,
    input  logic                    mat_lat,
    input  logic                    mat_oe,
    input  logic                    err_clr,
    input  logic                    px_ready,
    output logic                    px_valid,
    output logic [5:0]              px_data,
    output logic [$clog2(COLS)-1:0] px_col,
    output logic [ROW_W-1:0]        px_row,
    output logic                    px_oe,
    output logic                    px_last,
    output logic [15:0]             line_cnt,
    output logic                    err_ovf,
    output logic                    err_overrun
);

    localparam int          AW = $clog2(COLS);
    localparam int          CW = $clog2(COLS + 1);
    localparam int unsigned SN = (SYNC < 2) ? 2 : SYNC;
    localparam int          BW = ROW_W + 9;

    logic [BW-1:0]    w_pin;
    logic [BW-1:0]    r_sync [SN];
    logic [ROW_W-1:0] w_s_row;
    logic             w_s_oe, w_s_lat, w_s_clk;
    logic [1:0]       w_s_r, w_s_g, w_s_b;
    logic             r_clk_d, r_lat_d;
    logic             w_clk_rise, w_lat_rise;

    assign w_pin = {mat_row, mat_oe, mat_lat, mat_clk, mat_b, mat_g, mat_r};
    assign {w_s_row, w_s_oe, w_s_lat, w_s_clk, w_s_b, w_s_g, w_s_r} = r_sync[SN-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SN; i++) begin
                r_sync[i] <= '0;
            end
            r_clk_d <= 1'b0;
            r_lat_d <= 1'b0;
        end else begin
            r_sync[0] <= w_pin;
            for (int unsigned i = 1; i < SN; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_clk_d <= w_s_clk;
            r_lat_d <= w_s_lat;
        end
    end

    assign w_clk_rise = w_s_clk & ~r_clk_d;
    assign w_lat_rise = w_s_lat & ~r_lat_d;

    // ---------------- write side ----------------
    logic [CW-1:0]    r_wcol;
    logic [CW-1:0]    r_len  [2];
    logic [ROW_W-1:0] r_lrow [2];
    logic [1:0]       r_loe;
    logic [15:0]      r_line_cnt;
    logic             r_err_ovf, r_err_ovr;
    logic             w_col_ok, w_pix, w_we, w_accept, w_drop;
    logic [CW-1:0]    w_col_after;
    logic             w_wsel, w_wbusy;
    logic [1:0]       w_busy;
    pixel_t           w_rdata;

    assign w_wbusy     = w_busy[w_wsel];
    assign w_col_ok    = r_wcol < CW'(COLS);
    assign w_pix       = w_clk_rise && w_col_ok;
    // A reader-owned bank is never overwritten; such a line is dropped at latch.
    assign w_we        = w_pix && !w_wbusy;
    assign w_col_after = r_wcol + CW'(w_pix);
    assign w_accept    = w_lat_rise && !w_wbusy;
    assign w_drop      = w_lat_rise && w_wbusy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcol     <= '0;
            r_line_cnt <= '0;
            r_err_ovf  <= 1'b0;
            r_err_ovr  <= 1'b0;
            r_loe      <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                r_len[b]  <= '0;
                r_lrow[b] <= '0;
            end
        end else begin
            if (w_lat_rise) begin
                r_wcol <= '0;
            end else if (w_pix) begin
                r_wcol <= r_wcol + CW'(1);
            end
            if (w_accept) begin
                r_len[w_wsel]  <= w_col_after;
                r_lrow[w_wsel] <= w_s_row;
                r_loe[w_wsel]  <= w_s_oe;
                r_line_cnt     <= r_line_cnt + 16'd1;
            end
            if (w_clk_rise && !w_col_ok) begin
                r_err_ovf <= 1'b1;
            end else if (err_clr) begin
                r_err_ovf <= 1'b0;
            end
            if (w_drop) begin
                r_err_ovr <= 1'b1;
            end else if (err_clr) begin
                r_err_ovr <= 1'b0;
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t        r_state, w_state_nxt;
    logic             r_rsel, w_rsel_nxt;
    logic [AW-1:0]    r_col, w_col_nxt, w_raddr;
    logic             r_valid;
    logic [ROW_W-1:0] r_row_o;
    logic             r_oe_o;
    logic             w_re, w_free, w_start, w_last;

    assign w_last = (CW'(r_col) + CW'(1)) == r_len[r_rsel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The read port always fetches the beat that will be shown next cycle,
    // so entering STREAM already has pixel 0 registered.
    always_comb begin
        w_state_nxt = r_state;
        w_rsel_nxt  = r_rsel;
        w_col_nxt   = r_col;
        w_raddr     = '0;
        w_re        = 1'b1;
        w_free      = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            RD_IDLE: begin
                if (w_busy[r_rsel]) begin
                    if (r_len[r_rsel] == '0) begin
                        w_free     = 1'b1;
                        w_rsel_nxt = ~r_rsel;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = RD_STREAM;
                        w_col_nxt   = '0;
                    end
                end
            end
            RD_STREAM: begin
                if (px_ready) begin
                    if (w_last) begin
                        w_free      = 1'b1;
                        w_rsel_nxt  = ~r_rsel;
                        w_state_nxt = RD_IDLE;
                        w_col_nxt   = '0;
                    end else begin
                        w_col_nxt = r_col + AW'(1);
                        w_raddr   = r_col + AW'(1);
                    end
                end else begin
                    w_re    = 1'b0;
                    w_raddr = r_col;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsel  <= 1'b0;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_row_o <= '0;
            r_oe_o  <= 1'b0;
        end else begin
            r_rsel  <= w_rsel_nxt;
            r_col   <= w_col_nxt;
            r_valid <= (w_state_nxt == RD_STREAM);
            if (w_start) begin
                r_row_o <= r_lrow[r_rsel];
                r_oe_o  <= r_loe[r_rsel];
            end
        end
    end

    hub75_linebuf #(
        .COLS(COLS)
    ) u_linebuf (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (AW'(r_wcol)),
        .i_wdata    (pack_px(w_s_r, w_s_g, w_s_b)),
        .i_handoff  (w_accept),
        .i_free     (w_free),
        .i_free_bank(r_rsel),
        .i_re       (w_re),
        .i_rbank    (w_rsel_nxt),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata),
        .o_wsel     (w_wsel),
        .o_busy     (w_busy)
    );

    assign px_valid    = r_valid;
    assign px_data     = w_rdata;
    assign px_col      = r_col;
    assign px_row      = r_row_o;
    assign px_oe       = r_oe_o;
    assign px_last     = r_valid && w_last;
    assign line_cnt    = r_line_cnt;
    assign err_ovf     = r_err_ovf;
    assign err_overrun = r_err_ovr;

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: drives HUB75 bus waveforms and compares streamed beats
// against a queue of expected beats built from the shifted pixels.
module tb_hub75_rx;

    localparam int COLS  = 32;
    localparam int ROW_W = 4;
    localparam int SYNC  = 2;
    localparam int CB    = $clog2(COLS);

    typedef logic [ROW_W+CB+7:0] beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mat_r = '0, mat_g = '0, mat_b = '0;
    logic [ROW_W-1:0] mat_row = '0;
    logic             mat_clk = 1'b0, mat_lat = 1'b0, mat_oe = 1'b0;
    logic             err_clr = 1'b0, px_ready = 1'b0;
    logic             px_valid, px_oe, px_last, err_ovf, err_overrun;
    logic [5:0]       px_data;
    logic [CB-1:0]    px_col;
    logic [ROW_W-1:0] px_row;
    logic [15:0]      line_cnt;

    always #5 clk = ~clk;

    hub75_rx #(.COLS(COLS), .ROW_W(ROW_W), .SYNC(SYNC)) dut (
        .clk(clk), .rst(rst), .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
        .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe),
        .err_clr(err_clr), .px_ready(px_ready), .px_valid(px_valid), .px_data(px_data),
        .px_col(px_col), .px_row(px_row), .px_oe(px_oe), .px_last(px_last),
        .line_cnt(line_cnt), .err_ovf(err_ovf), .err_overrun(err_overrun)
    );

    int total = 0;
    int bad   = 0;

    // model state
    logic [5:0] m_cur[$];
    beat_t      exp_q[$];
    int         m_owned = 0;
    int         m_cnt   = 0;
    bit         m_ovf   = 0;
    bit         m_ovr   = 0;

    beat_t cap_q[$];
    int    cap_cyc[$];
    int    stall_bad;

    function automatic beat_t mk_beat(input logic [ROW_W-1:0] row, input logic oe,
                                      input logic [CB-1:0] col, input logic last,
                                      input logic [5:0] d);
        return {row, oe, col, last, d};
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_px(input logic [5:0] px);
        mat_clk = 1'b0;
        {mat_b, mat_g, mat_r} = px;
        wait_neg(2);
        mat_clk = 1'b1;
        wait_neg(2);
        if (m_cur.size() < COLS) m_cur.push_back(px);
        else m_ovf = 1;
    endtask

    task automatic latch(input logic [ROW_W-1:0] row, input logic oe,
                         input bit coincide, input logic [5:0] px);
        mat_row = row;
        mat_oe  = oe;
        mat_clk = 1'b0;
        if (coincide) begin
            {mat_b, mat_g, mat_r} = px;
            wait_neg(2);
            mat_clk = 1'b1;
            if (m_cur.size() < COLS) m_cur.push_back(px);
            else m_ovf = 1;
        end
        mat_lat = 1'b1;
        wait_neg(2);
        mat_lat = 1'b0;
        mat_clk = 1'b0;
        wait_neg(2);
        if (m_owned < 2) begin
            for (int i = 0; i < m_cur.size(); i++)
                exp_q.push_back(mk_beat(row, oe, CB'(i), i == m_cur.size() - 1, m_cur[i]));
            if (m_cur.size() > 0) m_owned++;
            m_cnt++;
        end else begin
            m_ovr = 1;
        end
        m_cur.delete();
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic collect(input int cycles, input int mode);
        beat_t prev, cur;
        bit    stalled;
        stalled = 0;
        prev    = '0;
        cap_q.delete();
        cap_cyc.delete();
        stall_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cur = mk_beat(px_row, px_oe, px_col, px_last, px_data);
            if (stalled && (cur !== prev || px_valid !== 1'b1)) stall_bad++;
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = (c % 3 == 0);
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            if (px_valid && px_ready) begin
                cap_q.push_back(cur);
                cap_cyc.push_back(c);
                if (px_last) m_owned--;
            end
            stalled = px_valid && !px_ready;
            prev    = cur;
        end
        @(negedge clk);
        px_ready = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 0;
        m_ovr = 0;
        wait_neg(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_neg(4);
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", px_valid); end
        total++; if (px_data !== 6'd0) begin bad++; $display("FAIL reset_data: got %h want 0", px_data); end
        total++; if (px_col !== '0 || px_last !== 1'b0) begin bad++; $display("FAIL reset_col_last: got %0d/%b want 0/0", px_col, px_last); end
        total++; if (px_row !== '0 || px_oe !== 1'b0) begin bad++; $display("FAIL reset_row_oe: got %0d/%b want 0/0", px_row, px_oe); end
        total++; if (line_cnt !== 16'd0) begin bad++; $display("FAIL reset_line_cnt: got %0d want 0", line_cnt); end
        total++; if (err_ovf !== 1'b0 || err_overrun !== 1'b0) begin bad++; $display("FAIL reset_errs: got %b%b want 00", err_ovf, err_overrun); end
        rst = 1'b0;
        wait_neg(2);
    endtask

    task automatic test_basic();
        for (int i = 0; i < COLS; i++) shift_px(6'(i % 64));
        latch(4'd5, 1'b1, 0, 6'd0);
        collect(80, 0);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        if (cap_cyc.size() > 0) begin
            total++;
            if (cap_cyc[cap_cyc.size()-1] - cap_cyc[0] !== cap_cyc.size() - 1) begin
                bad++; $display("FAIL basic_rate: got span %0d want %0d", cap_cyc[cap_cyc.size()-1] - cap_cyc[0], cap_cyc.size() - 1);
            end
        end
        total++; if (line_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL basic_line_cnt: got %0d want %0d", line_cnt, m_cnt); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < COLS; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'($urandom), 0, 6'd0);
        collect(140, 1);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
        total++; if (line_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL bp_line_cnt: got %0d want %0d", line_cnt, m_cnt); end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < COLS + 8; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'b0, 0, 6'd0);
        collect(70, 0);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        total++; if (err_ovf !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", err_ovf, m_ovf); end
        total++; if (err_overrun !== m_ovr) begin bad++; $display("FAIL ovf_overrun: got %b want %b", err_overrun, m_ovr); end
        pulse_err_clr();
        total++; if (err_ovf !== m_ovf) begin bad++; $display("FAIL ovf_clear: got %b want %b", err_ovf, m_ovf); end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        px_ready = 1'b0;
        for (int i = 0; i < COLS; i++) shift_px(6'($urandom));
        latch(4'd1, 1'b1, 0, 6'd0);
        for (int i = 0; i < COLS; i++) shift_px(6'($urandom));
        latch(4'd2, 1'b0, 0, 6'd0);
        latch(4'd3, 1'b1, 0, 6'd0);
        wait_neg(5);
        total++; if (err_overrun !== m_ovr) begin bad++; $display("FAIL ovr_flag: got %b want %b", err_overrun, m_ovr); end
        total++; if (line_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL ovr_line_cnt: got %0d want %0d", line_cnt, m_cnt); end
        total++; if (px_valid !== 1'b1) begin bad++; $display("FAIL ovr_held_valid: got %b want 1", px_valid); end
        collect(120, 0);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL ovr_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        pulse_err_clr();
        total++; if (err_overrun !== m_ovr) begin bad++; $display("FAIL ovr_clear: got %b want %b", err_overrun, m_ovr); end
        exp_q.delete();
    endtask

    task automatic test_short_empty();
        for (int i = 0; i < 10; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'($urandom), 0, 6'd0);
        collect(60, 2);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL short_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        exp_q.delete();
        latch(4'd7, 1'b1, 0, 6'd0);
        collect(20, 0);
        total++; if (cap_q.size() !== 0) begin bad++; $display("FAIL empty_count: got %0d want 0", cap_q.size()); end
        total++; if (line_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL empty_line_cnt: got %0d want %0d", line_cnt, m_cnt); end
        for (int i = 0; i < 5; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'b1, 1, 6'($urandom));
        collect(40, 0);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL coinc_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL coinc_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        for (int i = 0; i < COLS + 1; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'b1, 0, 6'd0);
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            px_ready = 1'b1;
            if (px_valid && px_col == CB'(7)) found = 1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rstmid_reach7: got %b want 1", found); end
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", px_valid); end
        total++; if (line_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_line_cnt: got %0d want 0", line_cnt); end
        total++; if (err_ovf !== 1'b0 || err_overrun !== 1'b0) begin bad++; $display("FAIL rstmid_errs: got %b%b want 00", err_ovf, err_overrun); end
        px_ready = 1'b0;
        rst      = 1'b0;
        exp_q.delete();
        m_cur.delete();
        m_owned = 0;
        m_cnt   = 0;
        m_ovf   = 0;
        m_ovr   = 0;
        wait_neg(2);
        for (int i = 0; i < 8; i++) shift_px(6'($urandom));
        latch(4'($urandom), 1'($urandom), 0, 6'd0);
        collect(40, 0);
        total++;
        if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
        total++; if (line_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rstmid_line_cnt2: got %0d want %0d", line_cnt, m_cnt); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_overrun();
        test_short_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
